mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares the single unified instruction/data memory port between two requesters:
//   - instruction fetch (IF)
//   - load/store unit (LS)
//   Grants at most one access per cycle and drives the memory's rw/ain/din.
//   Routes the registered read data (1-cycle latency) back to the owner with a valid strobe.
//   Sits between the core pipeline and the memory block.
// PARAMETERS
//   ADDR_W        32  word-address width (memory is word addressed)
//   DATA_W        32  data width
//   STARVE_LIMIT  4   consecutive IF losses before IF is force-granted (1..15)
// PORTS
//   clock          in   1       rising-edge clock
//   reset          in   1       synchronous, active-low reset
//   if_req         in   1       IF read request; addr held stable until if_gnt
//   if_addr        in   ADDR_W  IF word address
//   if_gnt         out  1       IF request accepted this cycle (combinational)
//   if_rvalid      out  1       if_rdata valid (cycle after if_gnt)
//   if_rdata       out  DATA_W  IF read data
//   ls_req         in   1       LS request; we/addr/wdata held stable until ls_gnt
//   ls_we          in   1       1 = write, 0 = read
//   ls_addr        in   ADDR_W  LS word address
//   ls_wdata       in   DATA_W  LS write data
//   ls_gnt         out  1       LS request accepted this cycle (combinational)
//   ls_rvalid      out  1       ls_rdata valid (cycle after a read ls_gnt only)
//   ls_rdata       out  DATA_W  LS read data
//   mem_rw         out  1       to memory: 1 = write
//   mem_ain        out  ADDR_W  to memory: address
//   mem_din        out  DATA_W  to memory: write data
//   mem_dout       in   DATA_W  from memory: data read at previous edge
// BEHAVIOUR
//   - Arbitration (combinational, every cycle):
//     - LS wins over IF, unless starve_cnt == STARVE_LIMIT and if_req, then IF wins.
//     - Exactly one of if_gnt/ls_gnt may be high; neither is high when there is no request.
//   - Memory drive:
//     - IF grant: mem_rw=0, mem_ain=if_addr.
//     - LS grant: mem_rw=ls_we, mem_ain=ls_addr, mem_din=ls_wdata.
//     - No grant: mem_rw=0, mem_ain/mem_din hold the last values (no spurious writes).
//   - Response FSM (one registered owner tag): states IDLE, RESP_IF, RESP_LS.
//     - Next state: RESP_IF on if_gnt; RESP_LS on a read ls_gnt; IDLE otherwise (incl. LS write).
//     - RESP_IF: if_rvalid=1, if_rdata=mem_dout.
//     - RESP_LS: ls_rvalid=1, ls_rdata=mem_dout.
//     - Rdata is don't-care when rvalid=0; drive 0.
//     - Back-to-back grants are allowed every cycle: full throughput, latency 1.
//   - starve_cnt (4-bit):
//     - +1 on each cycle with if_req && ls_gnt, saturating at STARVE_LIMIT.
//     - Cleared on if_gnt or when !if_req.
//   - LS write grant completes the write; no rvalid is issued for it.
//   - Reset (reset==0 at an edge): FSM=IDLE, starve_cnt=0, if_rvalid=ls_rvalid=0, rdata=0.
//     - Gnts are forced 0 and mem_rw=0 while reset is low.
//     - Any in-flight read is dropped, with no rvalid after reset.
//   - A requester that drops req before gnt simply loses its slot; no error.
// CONFIGURATION
//   ARB_PERF_EN defined:
//   - Adds outputs perf_if_cnt, perf_ls_cnt, perf_conflict_cnt (32-bit, out).
//   - perf_if_cnt and perf_ls_cnt count if_gnt and ls_gnt cycles.
//   - perf_conflict_cnt counts cycles with if_req && ls_req.
//   - All wrap modulo 2^32 and clear on reset.
//   ARB_PERF_EN undefined: the ports and counters do not exist; arbitration is identical.
// STRUCTURE
//   - Shared package mem_arb_pkg:
//     - FSM state typedef/localparams (IDLE, RESP_IF, RESP_LS).
//     - Requester ID constants (REQ_IF=0, REQ_LS=1).
//     - Default ADDR_W/DATA_W.
//   - One natural sub-module: arb_starve_ctr (saturating starvation counter plus force flag).
//   - Everything else is flat in this module.
// TESTING
//   1. IF only: if_req=1, addr 0x10 with mem[0x10]=0xDEADBEEF
//      -> if_gnt same cycle; next cycle if_rvalid=1, if_rdata=0xDEADBEEF.
//   2. LS write then read: write 0x55 to addr 3 (ls_gnt, mem_rw=1, no ls_rvalid);
//      read addr 3 next cycle -> ls_rvalid=1, ls_rdata=0x55 one cycle later.
//   3. Conflict: if_req and ls_req held high with LS reads, STARVE_LIMIT=4
//      -> LS granted 4 cycles, IF granted on the 5th cycle, then LS resumes; never two gnts.
//   4. Back-to-back: alternating IF/LS reads every cycle -> one rvalid per cycle, correct owner/data.
//   5. Reset mid-read: reset low the cycle after if_gnt
//      -> if_rvalid stays 0, state IDLE, starve_cnt=0, mem_rw=0.
//   6. ARB_PERF_EN: 10 conflict cycles
//      -> perf_conflict_cnt=10; perf_if_cnt+perf_ls_cnt equals the total grants.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter.
// Response-owner FSM states, requester IDs and default widths.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Requester identifiers used for the winner select
  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

  // Owner of the read data returning from memory next cycle
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RESP_IF = 2'd1,
    RESP_LS = 2'd2
  } resp_state_e;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive cycles in which IF waited while LS was
// granted. Raises force_if_o once IF has lost LIMIT times in a row.
module arb_starve_ctr #(
  parameter int LIMIT = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic if_req_i,
  input  logic if_gnt_i,
  input  logic ls_gnt_i,
  output logic force_if_o
);

  localparam logic [3:0] LIMIT_C = 4'(LIMIT);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Next count: clear when IF is served or stops asking, else count LS wins
  always_comb begin
    cnt_d = cnt_q;
    if (!if_req_i || if_gnt_i) begin
      cnt_d = 4'd0;
    end else if (ls_gnt_i && (cnt_q < LIMIT_C)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Counter register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign force_if_o = if_req_i && (cnt_q == LIMIT_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch (IF)
// and the load/store unit (LS), and routes 1-cycle read data to its owner.
// Optional performance counters are enabled with the ARB_PERF_EN macro.
// Handshake: a requester holds req and its payload stable until the cycle
// its gnt is high; gnt is combinational and the access is taken at that
// clock edge. Read data returns with rvalid exactly one cycle later.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_rw,
  output logic [ADDR_W-1:0] mem_ain,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
`ifdef ARB_PERF_EN
  output logic [31:0]       perf_if_cnt,
  output logic [31:0]       perf_ls_cnt,
  output logic [31:0]       perf_conflict_cnt,
`endif
  output logic [1:0]        dbg_state
);

  resp_state_e       state_q;
  resp_state_e       state_d;
  logic              force_if;
  logic              gnt_any;
  logic              gnt_sel;
  logic [ADDR_W-1:0] ain_q;
  logic [ADDR_W-1:0] ain_d;
  logic [DATA_W-1:0] din_q;
  logic [DATA_W-1:0] din_d;

  arb_starve_ctr #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk_i      (clock),
    .rst_ni     (reset),
    .if_req_i   (if_req),
    .if_gnt_i   (if_gnt),
    .ls_gnt_i   (ls_gnt),
    .force_if_o (force_if)
  );

  // Winner select: LS has priority unless IF has starved; no grants in reset
  always_comb begin
    gnt_any = 1'b0;
    gnt_sel = REQ_IF;
    if (reset) begin
      if (force_if) begin
        gnt_any = 1'b1;
        gnt_sel = REQ_IF;
      end else if (ls_req) begin
        gnt_any = 1'b1;
        gnt_sel = REQ_LS;
      end else if (if_req) begin
        gnt_any = 1'b1;
        gnt_sel = REQ_IF;
      end
    end
  end

  assign if_gnt = gnt_any && (gnt_sel == REQ_IF);
  assign ls_gnt = gnt_any && (gnt_sel == REQ_LS);

  // Memory drive: idle cycles replay the last address/data with rw low
  always_comb begin
    mem_rw  = 1'b0;
    mem_ain = ain_q;
    mem_din = din_q;
    if (gnt_any) begin
      if (gnt_sel == REQ_LS) begin
        mem_rw  = ls_we;
        mem_ain = ls_addr;
        mem_din = ls_wdata;
      end else begin
        mem_ain = if_addr;
      end
    end
    ain_d = mem_ain;
    din_d = mem_din;
  end

  // Hold registers for the idle memory address/data
  always_ff @(posedge clock) begin
    if (!reset) begin
      ain_q <= '0;
      din_q <= '0;
    end else begin
      ain_q <= ain_d;
      din_q <= din_d;
    end
  end

  // Response FSM state register; reset drops any in-flight read
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Response FSM next state: remember who owns next cycle's read data
  always_comb begin
    state_d = IDLE;
    if (if_gnt) begin
      state_d = RESP_IF;
    end else if (ls_gnt && !ls_we) begin
      state_d = RESP_LS;
    end
  end

  // Response FSM outputs: steer mem_dout to the owner, zero otherwise
  always_comb begin
    if_rvalid = 1'b0;
    if_rdata  = '0;
    ls_rvalid = 1'b0;
    ls_rdata  = '0;
    if (reset) begin
      case (state_q)
        RESP_IF: begin
          if_rvalid = 1'b1;
          if_rdata  = mem_dout;
        end
        RESP_LS: begin
          ls_rvalid = 1'b1;
          ls_rdata  = mem_dout;
        end
        default: ;
      endcase
    end
  end

  assign dbg_state = state_q;

`ifdef ARB_PERF_EN
  // Grant and conflict counters, wrapping modulo 2^32
  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_if_cnt       <= 32'd0;
      perf_ls_cnt       <= 32'd0;
      perf_conflict_cnt <= 32'd0;
    end else begin
      perf_if_cnt       <= perf_if_cnt + {31'd0, if_gnt};
      perf_ls_cnt       <= perf_ls_cnt + {31'd0, ls_gnt};
      perf_conflict_cnt <= perf_conflict_cnt + {31'd0, if_req && ls_req};
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// transaction-level model (priority rule, loss counter, response queue,
// shadow memory).
module tb_mem_port_arbiter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int LIMIT = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          ls_req = 1'b0;
  logic          ls_we = 1'b0;
  logic [AW-1:0] ls_addr = '0;
  logic [DW-1:0] ls_wdata = '0;
  logic          ls_gnt, ls_rvalid;
  logic [DW-1:0] ls_rdata;
  logic          mem_rw;
  logic [AW-1:0] mem_ain;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout = '0;
  logic [1:0]    dbg_state;
`ifdef ARB_PERF_EN
  logic [31:0]   perf_if_cnt, perf_ls_cnt, perf_conflict_cnt;
`endif

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clock(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_rw(mem_rw), .mem_ain(mem_ain), .mem_din(mem_din), .mem_dout(mem_dout),
`ifdef ARB_PERF_EN
    .perf_if_cnt(perf_if_cnt), .perf_ls_cnt(perf_ls_cnt),
    .perf_conflict_cnt(perf_conflict_cnt),
`endif
    .dbg_state(dbg_state)
  );

  function automatic logic [31:0] init_word(input int i);
    return (32'(i) * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  // Environment memory: registered read, write on mem_rw, reloaded in reset
  logic [31:0] env_mem [0:255];
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= init_word(i);
    end else begin
      if (mem_rw) env_mem[mem_ain[7:0]] <= mem_din;
      mem_dout <= env_mem[mem_ain[7:0]];
    end
  end

  // ---------------- scoreboard ----------------
  int tests_run = 0;
  int tests_failed = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [33:0] exp_q[$];          // {if_valid, ls_valid, data} due next cycle
  logic [31:0] ref_mem [0:255];
  int          starve = 0;
  logic        last_known = 1'b0;
  logic [31:0] last_ain = '0;
  logic [31:0] last_din = '0;
  logic        din_known = 1'b0;
`ifdef ARB_PERF_EN
  logic [31:0] m_if_cnt = '0, m_ls_cnt = '0, m_conf_cnt = '0;
`endif

  // Compare process: every cycle, away from the active edge
  always @(negedge clk) begin
    logic [33:0] e;
    logic e_if, e_ls, eg_if, eg_ls;
    logic [31:0] rd;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 34'd0;
    e_if = e[33] && reset;
    e_ls = e[32] && reset;
    chk("if_rvalid", 64'(if_rvalid), 64'(e_if));
    chk("if_rdata", 64'(if_rdata), e_if ? 64'(e[31:0]) : 64'd0);
    chk("ls_rvalid", 64'(ls_rvalid), 64'(e_ls));
    chk("ls_rdata", 64'(ls_rdata), e_ls ? 64'(e[31:0]) : 64'd0);

    eg_if = 1'b0;
    eg_ls = 1'b0;
    if (reset) begin
      if (if_req && starve == LIMIT) eg_if = 1'b1;
      else if (ls_req)               eg_ls = 1'b1;
      else if (if_req)               eg_if = 1'b1;
    end
    chk("if_gnt", 64'(if_gnt), 64'(eg_if));
    chk("ls_gnt", 64'(ls_gnt), 64'(eg_ls));
    chk("mem_rw", 64'(mem_rw), 64'(eg_ls && ls_we));
    if (eg_if) chk("mem_ain_if", 64'(mem_ain), 64'(if_addr));
    if (eg_ls) chk("mem_ain_ls", 64'(mem_ain), 64'(ls_addr));
    if (eg_ls && ls_we) chk("mem_din", 64'(mem_din), 64'(ls_wdata));
    if (!eg_if && !eg_ls && last_known) chk("mem_ain_hold", 64'(mem_ain), 64'(last_ain));
    if (!eg_if && !eg_ls && din_known) chk("mem_din_hold", 64'(mem_din), 64'(last_din));
`ifdef ARB_PERF_EN
    chk("perf_if", 64'(perf_if_cnt), 64'(m_if_cnt));
    chk("perf_ls", 64'(perf_ls_cnt), 64'(m_ls_cnt));
    chk("perf_conf", 64'(perf_conflict_cnt), 64'(m_conf_cnt));
`endif

    // Advance the model to the state after the coming edge
    if (!reset) begin
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      exp_q.delete();
      starve = 0;
      last_known = 1'b0;
      din_known = 1'b0;
`ifdef ARB_PERF_EN
      m_if_cnt = '0; m_ls_cnt = '0; m_conf_cnt = '0;
`endif
    end else begin
      rd = eg_if ? ref_mem[if_addr[7:0]] : ref_mem[ls_addr[7:0]];
      exp_q.push_back({eg_if, eg_ls && !ls_we, rd});
      if (eg_ls && ls_we) ref_mem[ls_addr[7:0]] = ls_wdata;
      if (!if_req || eg_if) starve = 0;
      else if (eg_ls && starve < LIMIT) starve = starve + 1;
      if (eg_if) begin last_ain = if_addr; last_known = 1'b1; end
      if (eg_ls) begin
        last_ain = ls_addr; last_din = ls_wdata;
        last_known = 1'b1; din_known = 1'b1;
      end
`ifdef ARB_PERF_EN
      m_if_cnt   = m_if_cnt + 32'(eg_if);
      m_ls_cnt   = m_ls_cnt + 32'(eg_ls);
      m_conf_cnt = m_conf_cnt + 32'(if_req && ls_req);
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_if(input logic r, input logic [31:0] a);
    if_req = r;
    if_addr = a;
  endtask

  task automatic set_ls(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    ls_req = r;
    ls_we = w;
    ls_addr = a;
    ls_wdata = d;
  endtask

  // Both requesters held high with LS reads: LS x4, IF, LS x4, IF
  task automatic starve_run(input string tag);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk({tag, "_if_gnt"}, 64'(if_gnt), 64'(k % 5 == 4));
      chk({tag, "_ls_gnt"}, 64'(ls_gnt), 64'(k % 5 != 4));
      chk({tag, "_one_gnt"}, 64'(if_gnt && ls_gnt), 64'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic gi, gl;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_state", 64'(dbg_state), 64'd0);
    chk("reset_gnt", 64'({if_gnt, ls_gnt, mem_rw}), 64'd0);
    #1;
    set_if(1'b1, 32'h10);
    set_ls(1'b1, 1'b0, 32'h3, 32'h0);
    @(negedge clk);
    chk("reset_forces_gnt0", 64'({if_gnt, ls_gnt}), 64'd0);
    set_if(1'b0, 32'h0);
    set_ls(1'b0, 1'b0, 32'h0, 32'h0);
    step();
    reset = 1'b1;

    // Preload 0xDEADBEEF at 0x10, then IF-only fetch of it
    step();
    set_ls(1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF);
    @(negedge clk);
    chk("pre_ls_gnt", 64'(ls_gnt), 64'd1);
    chk("pre_mem_rw", 64'(mem_rw), 64'd1);
    step();
    set_ls(1'b0, 1'b0, 32'h0, 32'h0);
    set_if(1'b1, 32'h10);
    @(negedge clk);
    chk("if_only_gnt", 64'(if_gnt), 64'd1);
    chk("write_no_rvalid", 64'(ls_rvalid), 64'd0);
    step();
    set_if(1'b0, 32'h0);
    @(negedge clk);
    chk("if_only_rvalid", 64'(if_rvalid), 64'd1);
    chk("if_only_rdata", 64'(if_rdata), 64'hDEAD_BEEF);

    // LS write 0x55 to 3, then read it back
    step();
    set_ls(1'b1, 1'b1, 32'h3, 32'h55);
    @(negedge clk);
    chk("ls_wr_gnt", 64'({ls_gnt, mem_rw}), 64'b11);
    step();
    set_ls(1'b1, 1'b0, 32'h3, 32'h0);
    @(negedge clk);
    chk("ls_wr_no_rvalid", 64'(ls_rvalid), 64'd0);
    chk("ls_rd_gnt", 64'({ls_gnt, mem_rw}), 64'b10);
    step();
    set_ls(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("ls_rd_rvalid", 64'(ls_rvalid), 64'd1);
    chk("ls_rd_rdata", 64'(ls_rdata), 64'h55);

    // Conflict / starvation
    step();
    set_if(1'b1, 32'h5);
    set_ls(1'b1, 1'b0, 32'h6, 32'h0);
    starve_run("starve");
    step();
    set_if(1'b0, 32'h0);
    set_ls(1'b0, 1'b0, 32'h0, 32'h0);

    // Back-to-back alternating IF/LS reads
    for (int k = 0; k < 8; k++) begin
      step();
      if (k % 2 == 0) begin
        set_if(1'b1, 32'(k + 16));
        set_ls(1'b0, 1'b0, 32'h0, 32'h0);
      end else begin
        set_if(1'b0, 32'h0);
        set_ls(1'b1, 1'b0, 32'(k + 32), 32'h0);
      end
      @(negedge clk);
      if (k > 0) chk("b2b_owner", 64'({if_rvalid, ls_rvalid}), (k % 2 == 1) ? 64'b10 : 64'b01);
    end
    step();
    set_if(1'b0, 32'h0);
    set_ls(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("b2b_last_owner", 64'({if_rvalid, ls_rvalid}), 64'b01);

    // Reset the cycle after an IF grant
    step();
    set_if(1'b1, 32'h10);
    @(negedge clk);
    chk("rst_if_gnt", 64'(if_gnt), 64'd1);
    step();
    reset = 1'b0;
    set_if(1'b0, 32'h0);
    @(negedge clk);
    chk("rst_no_rvalid", 64'(if_rvalid), 64'd0);
    chk("rst_mem_rw", 64'(mem_rw), 64'd0);
    step();
    @(negedge clk);
    chk("rst_state_idle", 64'(dbg_state), 64'd0);
    chk("rst_rvalid_after", 64'(if_rvalid), 64'd0);
    step();
    reset = 1'b1;
    set_if(1'b1, 32'h5);
    set_ls(1'b1, 1'b0, 32'h6, 32'h0);
    starve_run("post_rst");
    step();
    set_if(1'b0, 32'h0);
    set_ls(1'b0, 1'b0, 32'h0, 32'h0);
`ifdef ARB_PERF_EN
    @(negedge clk);
    chk("perf_conf_10", 64'(perf_conflict_cnt), 64'd10);
    chk("perf_total", 64'(perf_if_cnt + perf_ls_cnt), 64'd10);
    chk("perf_if_2", 64'(perf_if_cnt), 64'd2);
`endif

    // Randomized traffic; requests held until granted, occasionally dropped
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      gi = if_gnt;
      gl = ls_gnt;
      step();
      reset = ($urandom_range(0, 299) != 0);
      if (!if_req || gi || $urandom_range(0, 15) == 0)
        set_if($urandom_range(0, 3) != 0, 32'($urandom_range(0, 31)));
      if (!ls_req || gl || $urandom_range(0, 15) == 0)
        set_ls($urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0,
               32'($urandom_range(0, 31)), $urandom);
    end
    step();
    reset = 1'b1;
    set_if(1'b0, 32'h0);
    set_ls(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
